// File: rtl/hazard_unit_if.sv
// ID-stage decode fields in, per-source hazard flags and stall control out.
interface hazard_unit_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [REG_ADDR_W-1:0]  id_rs;
  logic [REG_ADDR_W-1:0]  id_rt;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic                   id_is_store;
  logic [REG_ADDR_W-1:0]  id_rd;
  logic                   id_writes_reg;
  logic                   id_is_load;
  logic                   hold;
  logic                   flush;

  logic                   stall;
  logic                   has_reg1_hazard;
  logic                   has_reg2_hazard;
  logic                   has_saved_val_hazard;
  logic                   is_reg1_EXE_hazard;
  logic                   is_reg1_MEM_hazard;
  logic                   is_reg1_WB_hazard;
  logic                   is_reg2_EXE_hazard;
  logic                   is_reg2_MEM_hazard;
  logic                   is_reg2_WB_hazard;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_store,
           id_rd, id_writes_reg, id_is_load, hold, flush,
    input  stall, has_reg1_hazard, has_reg2_hazard, has_saved_val_hazard,
           is_reg1_EXE_hazard, is_reg1_MEM_hazard, is_reg1_WB_hazard,
           is_reg2_EXE_hazard, is_reg2_MEM_hazard, is_reg2_WB_hazard,
           stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_store,
           id_rd, id_writes_reg, id_is_load, hold, flush,
    output stall, has_reg1_hazard, has_reg2_hazard, has_saved_val_hazard,
           is_reg1_EXE_hazard, is_reg1_MEM_hazard, is_reg1_WB_hazard,
           is_reg2_EXE_hazard, is_reg2_MEM_hazard, is_reg2_WB_hazard,
           stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// ID-stage hazard detection: shadow EXE/MEM/WB destination slots, per-stage
// source match flags for the forwarding mux, load-use stall and stall counter.
module hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_unit_if.slave  hif
);

  typedef struct packed {
    logic                  valid;
    logic                  writes;
    logic [REG_ADDR_W-1:0] dst;
    logic                  is_load;
  } slot_t;

  slot_t                  exe_q, exe_d;
  slot_t                  mem_q, mem_d;
  slot_t                  wb_q,  wb_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic need_rs, need_rt;
  logic rs_exe, rs_mem, rs_wb;
  logic rt_exe, rt_mem, rt_wb;
  logic rs_ld, rt_ld, ld_hit;
  logic stall_w, issue;

  function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid && s.writes && (s.dst == r) && (r != '0);
  endfunction

  always_comb begin
    need_rs = hif.id_valid && hif.id_uses_rs;
    need_rt = hif.id_valid && (hif.id_uses_rt || hif.id_is_store);

    rs_exe = need_rs && slot_match(exe_q, hif.id_rs);
    rs_mem = need_rs && slot_match(mem_q, hif.id_rs);
    rs_wb  = need_rs && slot_match(wb_q,  hif.id_rs);
    rt_exe = need_rt && slot_match(exe_q, hif.id_rt);
    rt_mem = need_rt && slot_match(mem_q, hif.id_rt);
    rt_wb  = need_rt && slot_match(wb_q,  hif.id_rt);

    // Nearest matching slot wins: a younger non-load write shadows an older load.
    rs_ld = rs_exe ? exe_q.is_load : (rs_mem ? mem_q.is_load : 1'b0);
    rt_ld = rt_exe ? exe_q.is_load : (rt_mem ? mem_q.is_load : 1'b0);
    ld_hit = rs_ld || rt_ld;

    stall_w = hif.id_valid && ld_hit && !hif.flush && rst_n;
    issue   = hif.id_valid && !stall_w && !hif.flush;
  end

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!hif.hold) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      exe_d = '0;
      if (issue) begin
        exe_d = '{valid: 1'b1, writes: hif.id_writes_reg,
                  dst: hif.id_rd, is_load: hif.id_is_load};
      end
      if (stall_w && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign hif.stall                = stall_w;
  assign hif.is_reg1_EXE_hazard   = rst_n && rs_exe;
  assign hif.is_reg1_MEM_hazard   = rst_n && rs_mem;
  assign hif.is_reg1_WB_hazard    = rst_n && rs_wb;
  assign hif.is_reg2_EXE_hazard   = rst_n && rt_exe;
  assign hif.is_reg2_MEM_hazard   = rst_n && rt_mem;
  assign hif.is_reg2_WB_hazard    = rst_n && rt_wb;
  assign hif.has_reg1_hazard      = rst_n && (rs_exe || rs_mem || rs_wb);
  assign hif.has_reg2_hazard      = rst_n && hif.id_uses_rt && (rt_exe || rt_mem || rt_wb);
  assign hif.has_saved_val_hazard = rst_n && hif.id_is_store && (rt_exe || rt_mem || rt_wb);
  assign hif.stall_cycles         = rst_n ? cnt_q : '0;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding flags, load-use stalls, hold,
// flush, reset and counter saturation (second instance with a 4-bit counter).
module tb_hazard_unit;

  localparam logic [9:0] S   = 10'b10_0000_0000;
  localparam logic [9:0] H1  = 10'b01_0000_0000;
  localparam logic [9:0] H2  = 10'b00_1000_0000;
  localparam logic [9:0] HSV = 10'b00_0100_0000;
  localparam logic [9:0] R1E = 10'b00_0010_0000;
  localparam logic [9:0] R1M = 10'b00_0001_0000;
  localparam logic [9:0] R1W = 10'b00_0000_1000;
  localparam logic [9:0] R2E = 10'b00_0000_0100;
  localparam logic [9:0] R2M = 10'b00_0000_0010;
  localparam logic [9:0] R2W = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b0;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  hazard_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) hif ();
  hazard_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(4))  hif4 ();

  hazard_unit #(.REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hif(hif.slave));
  hazard_unit #(.REG_ADDR_W(5), .STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hif(hif4.slave));

  assign hif4.id_valid      = hif.id_valid;
  assign hif4.id_rs         = hif.id_rs;
  assign hif4.id_rt         = hif.id_rt;
  assign hif4.id_uses_rs    = hif.id_uses_rs;
  assign hif4.id_uses_rt    = hif.id_uses_rt;
  assign hif4.id_is_store   = hif.id_is_store;
  assign hif4.id_rd         = hif.id_rd;
  assign hif4.id_writes_reg = hif.id_writes_reg;
  assign hif4.id_is_load    = hif.id_is_load;
  assign hif4.hold          = hif.hold;
  assign hif4.flush         = hif.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] flags();
    return {hif.stall, hif.has_reg1_hazard, hif.has_reg2_hazard, hif.has_saved_val_hazard,
            hif.is_reg1_EXE_hazard, hif.is_reg1_MEM_hazard, hif.is_reg1_WB_hazard,
            hif.is_reg2_EXE_hazard, hif.is_reg2_MEM_hazard, hif.is_reg2_WB_hazard};
  endfunction

  function automatic logic [9:0] flags4();
    return {hif4.stall, hif4.has_reg1_hazard, hif4.has_reg2_hazard, hif4.has_saved_val_hazard,
            hif4.is_reg1_EXE_hazard, hif4.is_reg1_MEM_hazard, hif4.is_reg1_WB_hazard,
            hif4.is_reg2_EXE_hazard, hif4.is_reg2_MEM_hazard, hif4.is_reg2_WB_hazard};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic st,
                        input logic [4:0] rd, input logic wr, input logic ld);
    hif.id_valid      = v;
    hif.id_rs         = rs;
    hif.id_rt         = rt;
    hif.id_uses_rs    = urs;
    hif.id_uses_rt    = urt;
    hif.id_is_store   = st;
    hif.id_rd         = rd;
    hif.id_writes_reg = wr;
    hif.id_is_load    = ld;
    #1;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    rst_n     = 1'b0;
    hif.hold  = 1'b0;
    hif.flush = 1'b0;
    // lw r5 that also reads r5: would hazard on anything if not held in reset
    set_id(1, 5, 5, 1, 1, 0, 5, 1, 1);
    chk("rst_flags_t0", 32'(flags()), 32'(NONE));
    chk("rst_cnt_t0", 32'(hif.stall_cycles), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_flags", 32'(flags()), 32'(NONE));
      chk("rst_cnt", 32'(hif.stall_cycles), 0);
      chk("rst_flags4", 32'(flags4()), 32'(NONE));
    end
    rst_n = 1'b1;
    set_id(1, 5, 6, 1, 1, 0, 5, 1, 0);
    chk("post_rst_first", 32'(flags()), 32'(NONE));
    step();
    drain();

    // add r3 then sub rs=r3
    set_id(1, 1, 2, 1, 1, 0, 3, 1, 0);
    chk("add_r3_issue", 32'(flags()), 32'(NONE));
    step();
    set_id(1, 3, 4, 1, 1, 0, 6, 1, 0);
    chk("sub_exe", 32'(flags()), 32'(H1 | R1E));
    idle();
    step();
    set_id(1, 3, 4, 1, 1, 0, 6, 1, 0);
    chk("sub_mem", 32'(flags()), 32'(H1 | R1M));
    idle();
    step();
    set_id(1, 3, 4, 1, 1, 0, 6, 1, 0);
    chk("sub_wb", 32'(flags()), 32'(H1 | R1W));
    step();
    drain();

    // lw r5 then add rs=r5: two stall cycles then WB forward
    set_id(1, 1, 0, 1, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 0, 1, 0, 0, 6, 1, 0);
    chk("lu_stall1", 32'(flags()), 32'(S | H1 | R1E));
    step();
    chk("lu_stall2", 32'(flags()), 32'(S | H1 | R1M));
    step();
    chk("lu_wb", 32'(flags()), 32'(H1 | R1W));
    chk("lu_cnt", 32'(hif.stall_cycles), 2);
    step();
    drain();

    // add r7 then sw with rt=r7 as saved value
    set_id(1, 1, 2, 1, 1, 0, 7, 1, 0);
    step();
    set_id(1, 2, 7, 1, 0, 1, 0, 0, 0);
    chk("sw_saved", 32'(flags()), 32'(HSV | R2E));
    step();
    drain();

    // same source via rt as ALU operand: reg2 summary, not saved
    set_id(1, 1, 2, 1, 1, 0, 8, 1, 0);
    step();
    set_id(1, 0, 8, 0, 1, 0, 9, 1, 0);
    chk("rt_alu_exe", 32'(flags()), 32'(H2 | R2E));
    step();
    drain();

    // destination r0, then non-writing instruction
    set_id(1, 1, 2, 1, 1, 0, 0, 1, 0);
    step();
    set_id(1, 0, 0, 1, 1, 0, 9, 0, 0);
    chk("dst_r0", 32'(flags()), 32'(NONE));
    step();
    set_id(1, 9, 0, 1, 1, 0, 10, 0, 0);
    chk("no_write", 32'(flags()), 32'(NONE));
    step();
    drain();

    // hold during a load-use stall
    set_id(1, 1, 0, 1, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 0, 1, 0, 0, 6, 1, 0);
    hif.hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", 32'(flags()), 32'(S | H1 | R1E));
      chk("hold_cnt", 32'(hif.stall_cycles), 2);
      step();
    end
    hif.hold = 1'b0;
    #1;
    chk("hold_rel_exe", 32'(flags()), 32'(S | H1 | R1E));
    step();
    chk("hold_rel_mem", 32'(flags()), 32'(S | H1 | R1M));
    chk("hold_rel_cnt3", 32'(hif.stall_cycles), 3);
    step();
    chk("hold_rel_wb", 32'(flags()), 32'(H1 | R1W));
    chk("hold_rel_cnt4", 32'(hif.stall_cycles), 4);
    step();
    drain();

    // flush with load-use: no stall, dependent becomes a bubble
    set_id(1, 1, 0, 1, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 0, 1, 0, 0, 6, 1, 0);
    hif.flush = 1'b1;
    #1;
    chk("flush_nostall", 32'(flags()), 32'(H1 | R1E));
    step();
    hif.flush = 1'b0;
    set_id(1, 6, 0, 1, 0, 0, 11, 1, 0);
    chk("flush_bubble", 32'(flags()), 32'(NONE));
    chk("flush_cnt", 32'(hif.stall_cycles), 4);
    idle();
    drain();

    // nearest match is a non-load: no stall
    set_id(1, 1, 0, 1, 0, 0, 5, 1, 1);
    step();
    set_id(1, 1, 0, 1, 0, 0, 5, 1, 0);
    step();
    set_id(1, 5, 0, 1, 0, 0, 6, 1, 0);
    chk("nearest_nonload", 32'(flags()), 32'(H1 | R1E | R1M));
    step();
    drain();

    // reset in the middle of a stall
    set_id(1, 1, 0, 1, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 0, 1, 0, 0, 6, 1, 0);
    chk("mid_rst_pre", 32'(flags()), 32'(S | H1 | R1E));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_drop", 32'(flags()), 32'(NONE));
    chk("mid_rst_cnt", 32'(hif.stall_cycles), 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_cleared", 32'(flags()), 32'(NONE));
    chk("mid_rst_cnt_after", 32'(hif.stall_cycles), 0);
    step();
    drain();

    // 10 load-use pairs = 20 stall cycles
    for (int k = 0; k < 10; k++) begin
      set_id(1, 1, 0, 1, 0, 0, 5, 1, 1);
      step();
      set_id(1, 5, 0, 1, 0, 0, 6, 1, 0);
      step();
      step();
      step();
      if (k == 6) begin
        chk("sat_cnt4_14", 32'(hif4.stall_cycles), 14);
      end
    end
    idle();
    chk("sat_cnt16", 32'(hif.stall_cycles), 20);
    chk("sat_cnt4", 32'(hif4.stall_cycles), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard detection and stall-control stage in the ID stage, directly upstream of the operand forwarding mux. It keeps a shadow pipeline of in-flight destination registers for the EXE, MEM and WB slots and compares them each cycle against the decoded ID-stage sources. It produces the per-source, per-stage hazard flags the forwarding mux consumes. It also raises a load-use stall and inserts bubbles when the needed value exists only at WB.

## Interface
- REG_ADDR_W, 5, register-index width; register 0 is hard-wired zero.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  source register indices.
- id_uses_rs, id_uses_rt  in  1  instruction reads rs / rt as an ALU operand.
- id_is_store  in  1  rt is read as the store (saved) value.
- id_rd  in  REG_ADDR_W  destination index, already muxed rd/rt.
- id_writes_reg, id_is_load  in  1  instruction writes id_rd / is a load.
- hold  in  1  global freeze from memory wait.
- flush  in  1  kill the ID instruction, e.g. taken branch.
- stall  out  1  hold PC and IF/ID; bubble into EXE.
- has_reg1_hazard, has_reg2_hazard, has_saved_val_hazard  out  1  source-level hazard summaries.
- is_reg1_EXE_hazard, is_reg1_MEM_hazard, is_reg1_WB_hazard  out  1  rs matches slot.
- is_reg2_EXE_hazard, is_reg2_MEM_hazard, is_reg2_WB_hazard  out  1  rt matches slot.
- stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles.

## Operation
- Shadow slots EXE, MEM, WB each hold {valid, writes, dst, is_load}.
- Reset:
  - All slot valid bits are 0 and stall_cycles is 0.
  - While rst_n=0, every output is forced to 0.
- Slot match X for source s: slot.valid && slot.writes && slot.dst==s && s!=0.
- is_reg1_X_hazard = id_valid && id_uses_rs && match X for id_rs.
  - The is_reg2_X_hazard flags use rt, qualified by (id_uses_rt || id_is_store).
  - All three stage flags are reported independently; the downstream mux applies EXE>MEM>WB priority.
- Hazard summaries:
  - has_reg1_hazard is the OR of the reg1 flags.
  - has_reg2_hazard is the OR of the reg2 flags, qualified by id_uses_rt.
  - has_saved_val_hazard is the OR of the reg2 flags, qualified by id_is_store.
- Load-use rule: MEM_data is the ALU result, so load data exists only at WB.
  - Let ld_hit = a needed source matches the EXE or MEM slot and that slot has is_load=1.
  - The nearest matching slot decides: if the nearest match is a non-load, no stall.
- stall = id_valid && ld_hit && !flush && rst_n.
- Slot advance, when hold=0:
  - WB takes MEM, MEM takes EXE.
  - EXE takes the ID fields if id_valid && !stall && !flush; otherwise EXE becomes a bubble (valid=0).
- hold=1: all slots and stall_cycles are frozen; flags and stall are still computed combinationally.
- stall_cycles increments when stall=1 && hold=0, saturating at all-ones; it never wraps.

## Timing
- Hazard flags and stall are combinational from the slot registers and ID inputs, valid within the same cycle.
- Slot updates occur at the clock edge; a newly issued instruction becomes visible in the EXE slot on the next cycle.
- Load-use latency:
  - A dependent instruction directly behind a load stalls 2 cycles.
  - On the third cycle it issues with is_*_WB_hazard=1.
  - With one independent instruction between them, the stall is 1 cycle.
- Simultaneous events:
  - flush with ld_hit gives stall=0 and a bubble into EXE.
  - hold with stall keeps stall asserted; there is no slot advance and no count.
- Reset mid-stall: stall drops in the reset cycle; the slots are cleared on that edge.

## Test plan
- Reset hold 3 cycles with id_valid=1 and matching inputs -> every output is 0 and stall_cycles=0; the first post-reset instruction sees no hazards.
- add r3 (writes r3), then sub using rs=r3 -> next cycle is_reg1_EXE_hazard=1 and has_reg1_hazard=1, stall=0; two cycles later, with bubbles in between, only is_reg1_WB_hazard=1.
- lw r5, then add rs=r5 -> stall=1 for exactly 2 cycles and stall_cycles=2, then is_reg1_WB_hazard=1 with stall=0.
- sw with rt=r7 behind add r7 -> has_saved_val_hazard=1 and is_reg2_EXE_hazard=1, has_reg2_hazard=0 (id_uses_rt=0).
- Destination r0, or id_writes_reg=0, with a matching source -> all flags 0.
- lw r5 plus dependent instruction, hold=1 for 3 cycles -> stall stays 1, slots frozen, stall_cycles unchanged.
- lw r5 plus dependent instruction, flush in the same cycle -> stall=0 and a bubble in EXE.
- STALL_CNT_W=4 with 20 stall cycles -> stall_cycles stays at 15.
